tlb_update_arbiter: RTL
=======================

TLB_UPDATE_ARBITER -- requirements
Module: tlb_update_arbiter

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 512: number of TLB entries.
REQ-002 SHALL have parameter WID, default $clog2(TLB_ENTRIES): entry index width.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port init_busy  input  1  reset-time TLB loader is still active.
REQ-006 SHALL have port init_entry_no  input  WID  loader target index.
REQ-007 SHALL have port init_entry  input  tlb_entry_t  loader entry.
REQ-008 SHALL have port ptw_req  input  1  page-walker refill request, held until ack.
REQ-009 SHALL have port ptw_entry_no / ptw_entry  input  WID / tlb_entry_t  walker target and data.
REQ-010 SHALL have port ptw_ack  output  1  walker write performed this cycle.
REQ-011 SHALL have port csr_req  input  1  software write request, held until ack.
REQ-012 SHALL have port csr_entry_no / csr_entry  input  WID / tlb_entry_t  software target and data.
REQ-013 SHALL have port csr_ack  output  1  software write performed this cycle.
REQ-014 SHALL have port flush_req  input  1  single-cycle pulse requesting invalidate of all unlocked entries.
REQ-015 SHALL have port flush_done  output  1  single-cycle pulse at flush completion.
REQ-016 SHALL have port tlb_rd_no  output  WID  TLB read index; tlb_rd_entry valid one cycle later.
REQ-017 SHALL have port tlb_rd_entry  input  tlb_entry_t  TLB read data.
REQ-018 SHALL have ports tlb_we / tlb_wr_no / tlb_wr_entry  output  1 / WID / tlb_entry_t  TLB write port.
REQ-019 SHALL have port busy  output  1  high when not in IDLE or init_busy high.

Function
REQ-020 SHALL implement states IDLE, FLUSH_RD, FLUSH_WR; write-port outputs and acks are combinational from state and inputs.
REQ-021 While init_busy=1, SHALL drive tlb_we=1, tlb_wr_no=init_entry_no, tlb_wr_entry=init_entry; ptw_ack=csr_ack=0; state held.
REQ-022 Write-port priority SHALL be: init loader > flush sequencer > PTW/CSR.
REQ-023 In IDLE with no pending flush, single requester SHALL be granted immediately: tlb_we=1, its index/data forwarded, its ack=1, same cycle.
REQ-024 PTW and CSR both requesting SHALL be resolved by a fairness bit: winner granted, bit flips to favour the loser; bit unchanged on uncontested grants.
REQ-025 flush_req in any state or during init_busy SHALL set flush_pending; a pulse arriving while pending is already set is absorbed.
REQ-026 In IDLE with flush_pending=1 and init_busy=0, SHALL clear pending, set idx=0, enter FLUSH_RD; no PTW/CSR grant that cycle.
REQ-027 FLUSH_RD: tlb_rd_no=idx, tlb_we=0, next state FLUSH_WR.
REQ-028 FLUSH_WR: tlb_we=1, tlb_wr_no=idx, tlb_wr_entry=tlb_rd_entry with pte.v forced 0 unless lock=1 (then unchanged).
REQ-029 FLUSH_WR with idx=TLB_ENTRIES-1 SHALL pulse flush_done, wrap idx to 0, return to IDLE; otherwise idx+1 and FLUSH_RD.
REQ-030 A flush SHALL take exactly 2*TLB_ENTRIES cycles from leaving IDLE to flush_done.
REQ-031 PTW/CSR acks SHALL be 0 throughout FLUSH_RD/FLUSH_WR; requests wait.
REQ-032 flush_req arriving during a flush SHALL cause a second full flush immediately after the first, with flush_done pulsing once per flush.
REQ-033 tlb_rd_no SHALL be 0 outside FLUSH_RD.

Reset
REQ-034 On rst: state=IDLE, idx=0, flush_pending=0, fairness favours PTW; outputs tlb_we=0, acks=0, flush_done=0, tlb_rd_no=0 (subject to REQ-021).
REQ-035 rst asserted mid-flush SHALL abort the sweep with no further writes and no flush_done.

Configuration
REQ-036 With macro TLB_FLUSH_SEQ_EN defined, SHALL include flush sequencer per REQ-025..032.
REQ-037 Without TLB_FLUSH_SEQ_EN, SHALL ignore flush_req, hold state IDLE, flush_done=0, tlb_rd_no=0; arbitration otherwise identical.

Verification
REQ-038 init_busy=1 for 64 cycles with ptw_req=1 -> 64 loader writes, ptw_ack=0 until cycle after init_busy falls, then ptw_ack=1.
REQ-039 ptw_req and csr_req held together for 4 grants -> ack order PTW, CSR, PTW, CSR; tlb_wr_no alternates matching indices.
REQ-040 TLB_ENTRIES=8, entries 2 and 5 locked, all valid, flush_req pulse -> flush_done exactly 16 cycles later; only entries 2 and 5 remain valid.
REQ-041 flush_req during init_busy -> flush starts first cycle after init_busy=0; csr_req held meanwhile acked only after flush_done.
REQ-042 rst asserted at idx=3 of a flush -> no tlb_we after reset, no flush_done, busy=0 next cycle.
REQ-043 Build without TLB_FLUSH_SEQ_EN, flush_req pulse with csr_req=1 -> csr_ack=1 same cycle, flush_done never asserts.

Source files
------------

// File: rtl/tlb_update_arbiter.sv
// TLB update arbiter: owns the single TLB write port and shares it between the
// reset-time loader, an optional invalidate-all flush sequencer and the
// page-walker / software (CSR) refill requesters.
// Build option: define TLB_FLUSH_SEQ_EN to include the flush sequencer; without
// it flush_req is ignored, the FSM stays in IDLE and flush_done stays low.

package tlb_update_arbiter_pkg;

   typedef struct packed {
      logic [19:0] ppn;
      logic [1:0]  rsw;
      logic        d;
      logic        a;
      logic        g;
      logic        u;
      logic        x;
      logic        w;
      logic        r;
      logic        v;
   } tlb_pte_t;

   typedef struct packed {
      logic        lock;   // locked entries survive a flush
      logic [15:0] asid;
      logic [26:0] vpn;
      tlb_pte_t    pte;
   } tlb_entry_t;

endpackage

module tlb_update_arbiter
   import tlb_update_arbiter_pkg::*;
#(
   parameter int TLB_ENTRIES = 512,
   parameter int WID         = $clog2(TLB_ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init_busy,
   input  logic [WID-1:0]   init_entry_no,
   input  tlb_entry_t       init_entry,
   input  logic             ptw_req,
   input  logic [WID-1:0]   ptw_entry_no,
   input  tlb_entry_t       ptw_entry,
   output logic             ptw_ack,
   input  logic             csr_req,
   input  logic [WID-1:0]   csr_entry_no,
   input  tlb_entry_t       csr_entry,
   output logic             csr_ack,
   input  logic             flush_req,
   output logic             flush_done,
   output logic [WID-1:0]   tlb_rd_no,
   input  tlb_entry_t       tlb_rd_entry,
   output logic             tlb_we,
   output logic [WID-1:0]   tlb_wr_no,
   output tlb_entry_t       tlb_wr_entry,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLUSH_RD = 2'd1,
      FLUSH_WR = 2'd2
   } state_t;

   localparam logic [WID-1:0] LAST_IDX = WID'(TLB_ENTRIES - 1);

   state_t         r_state;
   logic [WID-1:0] r_idx;
   logic           r_flush_pending;
   logic           r_fair;          // 0: PTW wins the next contested grant, 1: CSR wins

   state_t         w_state_next;
   logic [WID-1:0] w_idx_next;
   logic           w_flush_pending_next;
   logic           w_fair_next;
   logic           w_flush_in;      // flush request as seen by the sequencer

`ifdef TLB_FLUSH_SEQ_EN
   assign w_flush_in = flush_req;
`else
   // Sequencer left out: requests never reach it, so the FSM never leaves IDLE.
   logic w_unused_ok;
   assign w_flush_in  = 1'b0;
   assign w_unused_ok = flush_req;
`endif

   // Busy whenever a sweep is in progress or the loader still owns the port.
   assign busy = (r_state != IDLE) | init_busy;

   // State, sweep index, pending-flush flag and fairness bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= IDLE;
         r_idx           <= '0;
         r_flush_pending <= 1'b0;
         r_fair          <= 1'b0;
      end else begin
         r_state         <= w_state_next;
         r_idx           <= w_idx_next;
         r_flush_pending <= w_flush_pending_next;
         r_fair          <= w_fair_next;
      end
   end

   // Write-port mux, acks and next-state: loader > flush sweep > PTW/CSR.
   always_comb begin
      w_state_next         = r_state;
      w_idx_next           = r_idx;
      w_flush_pending_next = r_flush_pending | w_flush_in;
      w_fair_next          = r_fair;
      tlb_we               = 1'b0;
      tlb_wr_no            = '0;
      tlb_wr_entry         = '0;
      tlb_rd_no            = '0;
      ptw_ack              = 1'b0;
      csr_ack              = 1'b0;
      flush_done           = 1'b0;

      if (init_busy) begin
         // Loader owns the port; the FSM holds and any flush request stays latched.
         tlb_we       = 1'b1;
         tlb_wr_no    = init_entry_no;
         tlb_wr_entry = init_entry;
      end else if (!rst) begin
         // Reset suppresses all writes so an aborted sweep leaves no trace.
         case (r_state)
            IDLE: begin
               if (r_flush_pending | w_flush_in) begin
                  // Start the sweep; a request arriving now is folded into it.
                  w_flush_pending_next = 1'b0;
                  w_idx_next           = '0;
                  w_state_next         = FLUSH_RD;
               end else if (ptw_req && csr_req) begin
                  if (!r_fair) begin
                     tlb_we       = 1'b1;
                     tlb_wr_no    = ptw_entry_no;
                     tlb_wr_entry = ptw_entry;
                     ptw_ack      = 1'b1;
                  end else begin
                     tlb_we       = 1'b1;
                     tlb_wr_no    = csr_entry_no;
                     tlb_wr_entry = csr_entry;
                     csr_ack      = 1'b1;
                  end
                  w_fair_next = ~r_fair;
               end else if (ptw_req) begin
                  tlb_we       = 1'b1;
                  tlb_wr_no    = ptw_entry_no;
                  tlb_wr_entry = ptw_entry;
                  ptw_ack      = 1'b1;
               end else if (csr_req) begin
                  tlb_we       = 1'b1;
                  tlb_wr_no    = csr_entry_no;
                  tlb_wr_entry = csr_entry;
                  csr_ack      = 1'b1;
               end
            end
            FLUSH_RD: begin
               tlb_rd_no    = r_idx;
               w_state_next = FLUSH_WR;
            end
            FLUSH_WR: begin
               // Write back the entry read last cycle, invalidated unless locked.
               tlb_we       = 1'b1;
               tlb_wr_no    = r_idx;
               tlb_wr_entry = tlb_rd_entry;
               if (!tlb_rd_entry.lock) begin
                  tlb_wr_entry.pte.v = 1'b0;
               end
               if (r_idx == LAST_IDX) begin
                  flush_done   = 1'b1;
                  w_idx_next   = '0;
                  w_state_next = IDLE;
               end else begin
                  w_idx_next   = r_idx + WID'(1);
                  w_state_next = FLUSH_RD;
               end
            end
            default: begin
               w_state_next = IDLE;
            end
         endcase
      end
   end

endmodule
